// File: rtl/clk_rate_scheduler.sv
// Run-control and divider-rate scheduler: turns divided-clock rising edges into one-cycle
// processor enables under HALT/RUN/STEP control and retimes divider factor changes to an edge.
module clk_rate_scheduler #(
  parameter int unsigned FACTOR_W       = 32,
  parameter int unsigned DEFAULT_FACTOR = 1
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                div_clk,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [FACTOR_W-1:0] cmd_arg,
  output logic [FACTOR_W-1:0] divider_factor,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic [FACTOR_W-1:0] step_remaining
);

  typedef enum logic [1:0] {
    StHalt   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StSwitch = 2'b11
  } state_e;

  localparam logic [1:0] OpHalt      = 2'b00;
  localparam logic [1:0] OpRun       = 2'b01;
  localparam logic [1:0] OpStep      = 2'b10;
  localparam logic [1:0] OpSetFactor = 2'b11;

  localparam logic [FACTOR_W-1:0] FactorReset = FACTOR_W'(DEFAULT_FACTOR);
  localparam logic [FACTOR_W-1:0] One         = FACTOR_W'(1);

  state_e              state_q, state_d;
  state_e              saved_q, saved_d;
  logic                div_clk_q;
  logic                cpu_en_q, cpu_en_d;
  logic [FACTOR_W-1:0] step_q, step_d;
  logic [FACTOR_W-1:0] factor_q, factor_d;
  logic [FACTOR_W-1:0] target_q, target_d;

  logic tick;
  logic cmd_accept;

  assign tick       = div_clk & ~div_clk_q;
  assign cmd_accept = cmd_valid & cmd_ready;

  // State register together with the datapath flops it sequences.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= StHalt;
      saved_q   <= StHalt;
      div_clk_q <= 1'b0;
      cpu_en_q  <= 1'b0;
      step_q    <= '0;
      factor_q  <= FactorReset;
      target_q  <= FactorReset;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      div_clk_q <= div_clk;
      cpu_en_q  <= cpu_en_d;
      step_q    <= step_d;
      factor_q  <= factor_d;
      target_q  <= target_d;
    end
  end

  // Next-state: an accepted command always wins over a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    if (cmd_accept) begin
      unique case (cmd_op)
        OpHalt: state_d = StHalt;
        OpRun:  state_d = StRun;
        OpStep: state_d = (cmd_arg == '0) ? StHalt : StStep;
        OpSetFactor: begin
          saved_d = state_q;
          state_d = StSwitch;
        end
        default: state_d = state_q;
      endcase
    end else if (tick) begin
      unique case (state_q)
        StStep: begin
          if (step_q == One) state_d = StHalt;
        end
        StSwitch: state_d = saved_q;
        default:  state_d = state_q;
      endcase
    end
  end

  // Step counter, pending factor and applied factor.
  always_comb begin
    step_d   = step_q;
    factor_d = factor_q;
    target_d = target_q;
    if (cmd_accept) begin
      unique case (cmd_op)
        OpHalt, OpRun: step_d = '0;
        OpStep:        step_d = cmd_arg;
        OpSetFactor:   target_d = (cmd_arg == '0) ? One : cmd_arg;
        default:       step_d = step_q;
      endcase
    end else if (tick) begin
      unique case (state_q)
        // STEP is only ever entered with a non-zero count and leaves at 1->0.
        StStep:   step_d = step_q - One;
        StSwitch: factor_d = target_q;
        default:  step_d = step_q;
      endcase
    end
  end

  // Outputs: ready is combinational, the enable is computed here and registered.
  always_comb begin
    cmd_ready = (state_q != StSwitch);
    cpu_en_d  = 1'b0;
    if (!cmd_accept && tick) begin
      cpu_en_d = (state_q == StRun) || (state_q == StStep);
    end
  end

  assign divider_factor = factor_q;
  assign cpu_en         = cpu_en_q;
  assign state          = state_q;
  assign step_remaining = step_q;

endmodule

// File: tb/tb_clk_rate_scheduler.sv
// Directed bench for clk_rate_scheduler; expected enable pulses are queued when a div_clk
// rise is driven and retired by a negedge monitor.
module tb_clk_rate_scheduler;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        div_clk;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] divider_factor;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] step_remaining;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int half     = 2;
  int exp_q[$];

  clk_rate_scheduler #(
    .FACTOR_W       (32),
    .DEFAULT_FACTOR (1)
  ) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .div_clk        (div_clk),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_arg        (cmd_arg),
    .divider_factor (divider_factor),
    .cpu_en         (cpu_en),
    .state          (state),
    .step_remaining (step_remaining)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every cycle: cpu_en must be high exactly where a pulse was queued.
  always @(negedge in_clk) begin
    if (exp_q.size() != 0 && exp_q[0] == cyc) begin
      void'(exp_q.pop_front());
      chk("cpu_en_pulse", {63'd0, cpu_en}, 64'd1);
    end else begin
      chk("cpu_en_idle", {63'd0, cpu_en}, 64'd0);
    end
  end

  task automatic tick_cyc();
    @(posedge in_clk);
    #1;
  endtask

  // One full div_clk period; the tick lands in the cycle after the rise is driven.
  task automatic div_period(input bit expect_pulse);
    div_clk = 1'b1;
    if (expect_pulse) exp_q.push_back(cyc + 1);
    repeat (half) tick_cyc();
    div_clk = 1'b0;
    repeat (half) tick_cyc();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick_cyc();
    cmd_valid = 1'b0;
    cmd_arg   = '0;
  endtask

  initial begin
    in_rst_n  = 1'b1;
    div_clk   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    #2 in_rst_n = 1'b0;

    // Reset held with div_clk toggling.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) div_clk = ~div_clk;
      tick_cyc();
      chk("rst_factor", divider_factor, 1);
      chk("rst_state", state, 0);
    end
    chk("rst_step", step_remaining, 0);
    chk("rst_ready", cmd_ready, 1);
    div_clk  = 1'b1;
    in_rst_n = 1'b1;
    repeat (2) tick_cyc();
    div_clk = 1'b0;
    repeat (2) tick_cyc();
    chk("post_rst_state", state, 0);

    // RUN at factor 1: ten rises, ten pulses; then HALT silences it.
    send_cmd(2'b01, 32'd0);
    chk("run_state", state, 1);
    chk("run_step", step_remaining, 0);
    repeat (10) div_period(1'b1);
    send_cmd(2'b00, 32'd0);
    chk("halt_state", state, 0);
    repeat (3) div_period(1'b0);

    // STEP 3, then STEP 0.
    send_cmd(2'b10, 32'd3);
    chk("step3_state", state, 2);
    chk("step3_count", step_remaining, 3);
    for (int i = 2; i >= 0; i--) begin
      div_period(1'b1);
      chk("step3_dec", step_remaining, i);
    end
    chk("step3_done_state", state, 0);
    repeat (2) div_period(1'b0);
    send_cmd(2'b10, 32'd0);
    chk("step0_state", state, 0);
    chk("step0_count", step_remaining, 0);
    div_period(1'b0);

    // SET_FACTOR 2 while running.
    send_cmd(2'b01, 32'd0);
    div_period(1'b1);
    send_cmd(2'b11, 32'd2);
    chk("sf2_state", state, 3);
    chk("sf2_ready", cmd_ready, 0);
    tick_cyc();
    chk("sf2_ready_wait", cmd_ready, 0);
    chk("sf2_factor_old", divider_factor, 1);
    div_clk = 1'b1;
    chk("sf2_ready_edge", cmd_ready, 0);
    tick_cyc();
    chk("sf2_factor_new", divider_factor, 2);
    chk("sf2_return", state, 1);
    chk("sf2_ready_back", cmd_ready, 1);
    tick_cyc();
    div_clk = 1'b0;
    half = 4;
    repeat (half) tick_cyc();
    repeat (3) div_period(1'b1);

    // SET_FACTOR 0 (clamped to 1) while stepping with 5 left.
    send_cmd(2'b10, 32'd5);
    chk("step5_state", state, 2);
    send_cmd(2'b11, 32'd0);
    chk("sf0_state", state, 3);
    chk("sf0_step_kept", step_remaining, 5);
    tick_cyc();
    div_clk = 1'b1;
    tick_cyc();
    chk("sf0_factor", divider_factor, 1);
    chk("sf0_return", state, 2);
    chk("sf0_step", step_remaining, 5);
    repeat (half - 1) tick_cyc();
    div_clk = 1'b0;
    half = 2;
    repeat (half) tick_cyc();
    for (int i = 4; i >= 0; i--) begin
      div_period(1'b1);
      chk("step5_dec", step_remaining, i);
    end
    chk("step5_done_state", state, 0);

    // RUN accepted in the same cycle as a tick: that tick is swallowed.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    div_clk   = 1'b1;
    tick_cyc();
    cmd_valid = 1'b0;
    chk("same_cyc_state", state, 1);
    tick_cyc();
    div_clk = 1'b0;
    repeat (2) tick_cyc();
    div_period(1'b1);

    // Move to factor 3, then reset in the middle of a switch to 7.
    send_cmd(2'b11, 32'd3);
    chk("sf3_state", state, 3);
    tick_cyc();
    div_clk = 1'b1;
    tick_cyc();
    chk("sf3_factor", divider_factor, 3);
    chk("sf3_return", state, 1);
    tick_cyc();
    div_clk = 1'b0;
    repeat (2) tick_cyc();
    send_cmd(2'b11, 32'd7);
    chk("sf7_state", state, 3);
    repeat (2) tick_cyc();
    in_rst_n = 1'b0;
    #1;
    chk("midrst_factor", divider_factor, 1);
    chk("midrst_state", state, 0);
    chk("midrst_step", step_remaining, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (2) tick_cyc();
    in_rst_n = 1'b1;
    repeat (2) div_period(1'b0);
    chk("final_factor", divider_factor, 1);
    chk("pending_pulses", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_rate_scheduler.md
Name: clk_rate_scheduler

Overview:
- Run-control and rate-configuration controller for clock_divider.
- Owns the divider_factor input of clock_divider and observes its out_clk.
- Turns divided-clock rising edges into single-cycle processor enable pulses under HALT / RUN / STEP(N) control.
- Applies divider factor changes only on a divided-clock edge, with enables suppressed across the switch.

Parameters:
FACTOR_W, 32, width of divider factor and step count
DEFAULT_FACTOR, 1, divider_factor value after reset

Ports:
in_clk  input  1  system clock; all logic on rising edge
in_rst_n  input  1  asynchronous active-low reset
div_clk  input  1  out_clk of clock_divider, synchronous to in_clk
cmd_valid  input  1  command strobe
cmd_ready  output  1  command accept; transfer when cmd_valid & cmd_ready
cmd_op  input  2  00 HALT, 01 RUN, 10 STEP, 11 SET_FACTOR
cmd_arg  input  FACTOR_W  step count (STEP) or new factor (SET_FACTOR); ignored otherwise
divider_factor  output  FACTOR_W  registered, drives clock_divider
cpu_en  output  1  registered one-cycle processor enable pulse
state  output  2  00 HALT, 01 RUN, 10 STEP, 11 SWITCH
step_remaining  output  FACTOR_W  steps still to issue

Behaviour:
- Reset (async, in_rst_n=0) sets:
  - state=HALT, cpu_en=0, step_remaining=0, divider_factor=DEFAULT_FACTOR
  - div_clk_q=0, saved return state=HALT
- Reset mid-operation abandons any pending switch or steps.
- Edge detect:
  - div_clk_q <= div_clk each cycle.
  - tick = div_clk & ~div_clk_q (combinational, cycle T).
  - Any cpu_en response to that tick is high in cycle T+1 only.
- cmd_ready = (state != SWITCH), combinational.
- A command is accepted in cycle A when cmd_valid & cmd_ready. Its new state is visible in A+1.
- A tick in cycle A never produces cpu_en, whatever the command.
- HALT state: cpu_en stays 0; ticks are ignored.
- RUN state: every tick yields one cpu_en pulse.
- STEP state:
  - Every tick yields one cpu_en pulse and decrements step_remaining.
  - When step_remaining goes 1->0, state becomes HALT in the same update as that final pulse.
  - Exactly N pulses are issued.
- Command HALT: state=HALT and step_remaining=0 at A+1.
- Command RUN: state=RUN and step_remaining=0 at A+1.
- Command STEP:
  - cmd_arg=0: treated as HALT.
  - Otherwise: state=STEP, step_remaining=cmd_arg.
  - STEP while already in STEP overwrites the count; counts do not accumulate.
- Command SET_FACTOR:
  - Captures the target factor; cmd_arg=0 is clamped to 1.
  - Saves the current state (HALT/RUN/STEP) and step_remaining; enters SWITCH.
- SWITCH state:
  - cpu_en forced 0; cmd_ready=0.
  - On the first tick after A, divider_factor <= target, updated at T+1.
  - Also at T+1, state returns to the saved state with step_remaining unchanged.
  - That tick produces no pulse.
  - A factor equal to the current one still goes through SWITCH (one tick consumed).
- Widths: step_remaining decrement is FACTOR_W-bit and never underflows, because STEP exits at 0.
- divider_factor changes only in the cycle after a tick or on reset.
- cpu_en is never high in two consecutive cycles, since ticks are at least 2 cycles apart.

Test Plan:
- Reset with div_clk toggling:
  - Required: divider_factor=1, state=00, cpu_en=0 for 20 cycles.
  - Release in_rst_n while div_clk=1: no pulse.
- RUN with factor 1 (div_clk period 4 in_clk cycles):
  - Required: cpu_en pulses exactly 1 cycle after each div_clk rise; 10 rises -> 10 pulses.
  - Then HALT: zero pulses afterwards.
- STEP arg=3:
  - Required: exactly 3 pulses, step_remaining 3->2->1->0, state=00 after the third pulse.
  - STEP arg=0: state stays 00, no pulse.
- SET_FACTOR arg=2 while RUN:
  - Required: cmd_ready=0 until the next div_clk rise.
  - divider_factor=2 one cycle after that rise; that rise gives no pulse.
  - state returns to 01; later pulses track the slower div_clk.
- SET_FACTOR arg=0 while STEP with 5 remaining:
  - Required: divider_factor becomes 1, state returns to 10 with step_remaining=5, then 5 pulses and HALT.
- Command accepted in the same cycle as a tick (RUN issued from HALT):
  - Required: no pulse for that tick; next tick pulses.
  - Assert in_rst_n=0 mid-SWITCH: factor reverts to DEFAULT_FACTOR immediately.
